// File: rtl/burst_line_master_if.sv
// Request-side and BurstRAM-side signals of the line master, grouped into one bundle.
// The master modport is the line master's view; the slave modport is the
// requester/RAM view.
interface burst_line_master_if #(
  parameter int DATA_BITWIDTH  = 64,
  parameter int DEPTH_BITWIDTH = 8,
  parameter int BURST_COUNT    = 4
);
  logic                                   req;
  logic                                   req_we;
  logic [DEPTH_BITWIDTH-1:0]              req_addr;
  logic [BURST_COUNT*DATA_BITWIDTH-1:0]   req_wr_line;
  logic [BURST_COUNT*DATA_BITWIDTH-1:0]   rd_line;
  logic                                   done;
  logic                                   busy;
  logic                                   br_cmd;
  logic                                   br_cmd_en;
  logic [DEPTH_BITWIDTH-1:0]              br_addr;
  logic [DATA_BITWIDTH-1:0]               br_wr_data;
  logic [DATA_BITWIDTH/8-1:0]             br_data_mask;
  logic [DATA_BITWIDTH-1:0]               br_rd_data;
  logic                                   br_rd_data_valid;
  logic                                   br_busy;

  modport master (
    input  req, req_we, req_addr, req_wr_line,
    input  br_rd_data, br_rd_data_valid, br_busy,
    output rd_line, done, busy,
    output br_cmd, br_cmd_en, br_addr, br_wr_data, br_data_mask
  );

  modport slave (
    output req, req_we, req_addr, req_wr_line,
    output br_rd_data, br_rd_data_valid, br_busy,
    input  rd_line, done, busy,
    input  br_cmd, br_cmd_en, br_addr, br_wr_data, br_data_mask
  );
endinterface

// File: rtl/burst_line_master.sv
// Burst line master: turns one line request into a single BurstRAM burst
// command, streams the write beats out or collects the read beats into rd_line.
//
// state   | meaning
// INIT    | waiting for the RAM to come out of its own init (br_busy=0)
// IDLE    | waiting for a request; a request seen while br_busy=1 is held pending
// WRITE   | command issued, write beats 0..BURST_COUNT-1 driven on br_wr_data
// READ    | command issued, collecting read beats as br_rd_data_valid arrives
// DONE    | one-cycle completion pulse, back to IDLE
module burst_line_master #(
  parameter int DATA_BITWIDTH  = 64,
  parameter int DEPTH_BITWIDTH = 8,
  parameter int BURST_COUNT    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  burst_line_master_if.master  bus
);
  localparam int LINE_BITS = BURST_COUNT * DATA_BITWIDTH;
  localparam int CNT_BITS  = (BURST_COUNT > 1) ? $clog2(BURST_COUNT) : 1;
  localparam logic [CNT_BITS-1:0] LAST_BEAT = CNT_BITS'(BURST_COUNT - 1);

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_WRITE, S_READ, S_DONE} state_t;

  state_t                    state, state_nx;
  logic [CNT_BITS-1:0]       cnt, cnt_nx, cnt_inc;
  logic                      pend, pend_nx;
  logic                      line_we, line_we_nx;
  logic [DEPTH_BITWIDTH-1:0] line_addr, line_addr_nx;
  logic [LINE_BITS-1:0]      line_data, line_data_nx;
  logic [LINE_BITS-1:0]      rd_line_nx;
  logic                      cmd_en_nx, cmd_nx;
  logic [DEPTH_BITWIDTH-1:0] addr_nx;
  logic [DATA_BITWIDTH-1:0]  wr_data_nx;

  // A pending request replays the fields latched while the RAM was busy;
  // otherwise the live request fields are used directly.
  logic                      sel_we;
  logic [DEPTH_BITWIDTH-1:0] sel_addr;
  logic [LINE_BITS-1:0]      sel_line;
  logic                      accept;

  assign sel_we   = pend ? line_we   : bus.req_we;
  assign sel_addr = pend ? line_addr : bus.req_addr;
  assign sel_line = pend ? line_data : bus.req_wr_line;
  assign accept   = (state == S_IDLE) && (pend || bus.req) && !bus.br_busy;
  assign cnt_inc  = cnt + 1'b1;

  assign bus.br_data_mask = '0;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_INIT;
    else     state <= state_nx;
  end

  // Next-state decode.
  always_comb begin
    state_nx = state;
    case (state)
      S_INIT:  if (!bus.br_busy) state_nx = S_IDLE;
      S_IDLE:  if (accept) state_nx = sel_we ? S_WRITE : S_READ;
      S_WRITE: if (cnt == LAST_BEAT) state_nx = S_DONE;
      S_READ:  if (bus.br_rd_data_valid && (cnt == LAST_BEAT)) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_INIT;
    endcase
  end

  // Output decode: status flags plus next values of the registered outputs and datapath.
  always_comb begin
    bus.done     = (state == S_DONE);
    bus.busy     = (state == S_INIT) || (state == S_WRITE) || (state == S_READ) ||
                   ((state == S_IDLE) && (pend || (bus.req && bus.br_busy)));
    cnt_nx       = cnt;
    pend_nx      = pend;
    line_we_nx   = line_we;
    line_addr_nx = line_addr;
    line_data_nx = line_data;
    rd_line_nx   = bus.rd_line;
    cmd_en_nx    = 1'b0;
    cmd_nx       = 1'b0;
    addr_nx      = '0;
    wr_data_nx   = '0;
    case (state)
      S_IDLE: begin
        if (bus.req && !pend) begin
          line_we_nx   = bus.req_we;
          line_addr_nx = bus.req_addr;
          line_data_nx = bus.req_wr_line;
          pend_nx      = bus.br_busy;
        end
        if (accept) begin
          pend_nx      = 1'b0;
          line_data_nx = sel_line;
          cmd_en_nx    = 1'b1;
          cmd_nx       = sel_we;
          addr_nx      = sel_addr;
          cnt_nx       = '0;
          if (sel_we) wr_data_nx = sel_line[0 +: DATA_BITWIDTH];
        end
      end
      S_WRITE: begin
        if (cnt == LAST_BEAT) begin
          cnt_nx = '0;
        end else begin
          cnt_nx     = cnt_inc;
          wr_data_nx = line_data[cnt_inc*DATA_BITWIDTH +: DATA_BITWIDTH];
        end
      end
      S_READ: begin
        if (bus.br_rd_data_valid) begin
          rd_line_nx[cnt*DATA_BITWIDTH +: DATA_BITWIDTH] = bus.br_rd_data;
          cnt_nx = (cnt == LAST_BEAT) ? '0 : cnt_inc;
        end
      end
      default: cnt_nx = '0;
    endcase
  end

  // Registered command outputs, beat counter, latched request and read line.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt            <= '0;
      pend           <= 1'b0;
      line_we        <= 1'b0;
      line_addr      <= '0;
      line_data      <= '0;
      bus.rd_line    <= '0;
      bus.br_cmd_en  <= 1'b0;
      bus.br_cmd     <= 1'b0;
      bus.br_addr    <= '0;
      bus.br_wr_data <= '0;
    end else begin
      cnt            <= cnt_nx;
      pend           <= pend_nx;
      line_we        <= line_we_nx;
      line_addr      <= line_addr_nx;
      line_data      <= line_data_nx;
      bus.rd_line    <= rd_line_nx;
      bus.br_cmd_en  <= cmd_en_nx;
      bus.br_cmd     <= cmd_nx;
      bus.br_addr    <= addr_nx;
      bus.br_wr_data <= wr_data_nx;
    end
  end
endmodule

// File: doc/burst_line_master.md
BURST_LINE_MASTER -- requirements
Module: burst_line_master

Interface
- REQ-001 SHALL have parameter DATA_BITWIDTH, default 64: BurstRAM beat width in bits.
- REQ-002 SHALL have parameter DEPTH_BITWIDTH, default 8: BurstRAM address width.
- REQ-003 SHALL have parameter BURST_COUNT, default 4: beats per burst, a power of two.
- REQ-004 SHALL have port clk, input, 1: single clock for all logic.
- REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
- REQ-006 SHALL have port req, input, 1: line request strobe, sampled only when busy=0.
- REQ-007 SHALL have port req_we, input, 1: 1 = line write, 0 = line read.
- REQ-008 SHALL have port req_addr, input, DEPTH_BITWIDTH: burst start address.
- REQ-009 SHALL have port req_wr_line, input, BURST_COUNT*DATA_BITWIDTH: line to write; beat k is bits [k*DATA_BITWIDTH +: DATA_BITWIDTH].
- REQ-010 SHALL have port rd_line, output, BURST_COUNT*DATA_BITWIDTH: assembled read line, same beat order.
- REQ-011 SHALL have port done, output, 1: one-cycle completion pulse.
- REQ-012 SHALL have port busy, output, 1: high while initialising or serving a request.
- REQ-013 SHALL have port br_cmd, output, 1: 0 = read, 1 = write.
- REQ-014 SHALL have port br_cmd_en, output, 1: command strobe.
- REQ-015 SHALL have port br_addr, output, DEPTH_BITWIDTH: command address.
- REQ-016 SHALL have port br_wr_data, output, DATA_BITWIDTH: write beat.
- REQ-017 SHALL have port br_data_mask, output, DATA_BITWIDTH/8: byte mask.
- REQ-018 SHALL have port br_rd_data, input, DATA_BITWIDTH: read beat.
- REQ-019 SHALL have port br_rd_data_valid, input, 1: read beat valid.
- REQ-020 SHALL have port br_busy, input, 1: RAM not ready for commands.

Function
- REQ-021 SHALL implement states INIT, IDLE, WRITE, READ and DONE.
- REQ-022 INIT SHALL hold busy=1 and issue no command; it SHALL exit to IDLE on the first cycle br_busy=0.
- REQ-023 In IDLE, when req=1 and br_busy=0, the block SHALL register req_we, req_addr and req_wr_line, and SHALL assert br_cmd_en for exactly one cycle with br_cmd=req_we and br_addr=req_addr.
- REQ-024 In IDLE, a req seen while br_busy=1 SHALL NOT be lost: the block SHALL stay in IDLE, with busy=1, until br_busy=0, then issue the command.
- REQ-025 On a write, beat 0 SHALL be on br_wr_data in the br_cmd_en cycle; beats 1..BURST_COUNT-1 SHALL follow on consecutive cycles in state WRITE.
- REQ-026 A write SHALL enter DONE on the cycle after the last beat.
- REQ-027 br_data_mask SHALL be all zeros, meaning every byte is written.
- REQ-028 On a read, state READ SHALL store each cycle's br_rd_data into beat slot k whenever br_rd_data_valid=1, with k counting 0..BURST_COUNT-1.
- REQ-029 A read SHALL enter DONE on the cycle after beat BURST_COUNT-1 is captured; a gap in br_rd_data_valid SHALL only stall, not reset, the counter.
- REQ-030 br_rd_data_valid outside state READ SHALL be ignored.
- REQ-031 DONE SHALL last one cycle: done=1 and busy=0 in that cycle; the next state SHALL be IDLE.
- REQ-032 rd_line SHALL update only during a read and SHALL hold its value after done until the next read's beat 0.
- REQ-033 busy SHALL be 1 in INIT, WRITE and READ, 0 in IDLE unless REQ-024 applies, and 0 in DONE.
- REQ-034 Write latency SHALL be exactly BURST_COUNT+1 cycles from request acceptance to done.
- REQ-035 req in DONE SHALL be ignored; it SHALL be accepted the following cycle if still high.
- REQ-036 br_cmd_en, br_cmd, br_addr and br_wr_data SHALL be registered outputs.
- REQ-037 br_wr_data and br_addr SHALL be 0 when not in use.

Reset
- REQ-038 While rst=1, the block SHALL enter INIT, with done=0, br_cmd_en=0, br_cmd=0, br_addr=0, br_wr_data=0, rd_line=0, beat counter 0, and busy=1.
- REQ-039 rst asserted mid-burst SHALL abort the burst on the next clock with no further br_cmd_en; after rst falls, the block SHALL restart from INIT.

Verification
- REQ-040 Reset then idle: rst=1 for 2 cycles, br_busy=1 for 5 cycles after rst falls -> busy=1 throughout, no br_cmd_en; IDLE with busy=0 on the first cycle after br_busy falls.
- REQ-041 Line write: req_we=1, req_addr=8'h10, beats 64'h1111..., 64'h2222..., 64'h3333..., 64'h4444... -> one br_cmd_en with br_cmd=1 and br_addr=8'h10; those 4 beats on 4 consecutive cycles; done exactly 5 cycles after acceptance.
- REQ-042 Line read back: read of 8'h10 against a BurstRAM model with CYCLES_BEFORE_DATA_VALID=3 -> rd_line equals the line from REQ-041; done one cycle after the 4th valid beat.
- REQ-043 Stalled read: valid beats separated by idle cycles (pattern 1,0,1,1,0,0,1) -> beats land in slots 0..3 in order; exactly one done.
- REQ-044 Request during br_busy: req=1 while br_busy=1 for 3 cycles -> no br_cmd_en in those cycles; command issued on the first cycle br_busy=0.
- REQ-045 Reset mid-read: rst asserted after 2 valid beats -> no done; busy=1; a subsequent read returns the correct full line.
